// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-sequencer definitions: widths, reset PC, FSM state and IF/ID payload.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned INC  = 4;

    // Must track the PC register reset value.
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_ctrl_redirect_mux.sv
// Redirect detect and target select: trap beats mret beats branch.
module redirect_mux
    import fetch_ctrl_pkg::*;
(
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            redirect_c,
    output logic [XLEN-1:0] target_c
);

    always_comb begin
        redirect_c = trap_valid | mret_valid | br_taken;
        target_c   = br_target;
        if (trap_valid) begin
            target_c = trap_vec;
        end else if (mret_valid) begin
            target_c = mepc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC load control, single-outstanding imem handshake, stale-response kill.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc,
    output logic            pc_stall,
    output logic [XLEN-1:0] npc,
    input  logic            br_taken_exe,
    input  logic [XLEN-1:0] br_target_exe,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            if_valid,
    output logic [ILEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q;
    logic            if_valid_q;
    fetch_pkt_t      if_pkt_q;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic            handshake_c;
    logic            latch_req_c;
    logic            load_if_c;
    logic            clear_if_c;

    redirect_mux u_redirect_mux (
        .trap_valid (trap_valid),
        .trap_vec   (trap_vec),
        .mret_valid (mret_valid),
        .mepc       (mepc),
        .br_taken   (br_taken_exe),
        .br_target  (br_target_exe),
        .redirect_c (redirect_c),
        .target_c   (target_c)
    );

    // PC register control; the sequential add wraps naturally at XLEN bits.
    assign handshake_c   = imem_req_valid & imem_req_ready;
    assign imem_req_addr = pc;
    assign pc_stall      = ~(redirect_c | handshake_c);
    assign npc           = redirect_c ? target_c : pc + XLEN'(INC);

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        latch_req_c    = 1'b0;
        load_if_c      = 1'b0;
        clear_if_c     = 1'b0;
        case (state_q)
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    latch_req_c = 1'b1;
                    state_d     = redirect_c ? KILL : WAIT;
                end
            end
            WAIT: begin
                // A response coincident with a redirect is already stale: drop it here.
                if (redirect_c) begin
                    state_d = imem_resp_valid ? REQ : KILL;
                end else if (imem_resp_valid) begin
                    load_if_c = 1'b1;
                    state_d   = HOLD;
                end
            end
            KILL: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_c || id_ready) begin
                    clear_if_c = 1'b1;
                    state_d    = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= REQ;
            req_pc_q   <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_req_c) begin
                req_pc_q <= pc;
            end
            if (load_if_c) begin
                if_valid_q <= 1'b1;
                if_pkt_q   <= '{inst: imem_resp_data, pc: req_pc_q};
            end else if (clear_if_c) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    assign if_valid = if_valid_q;
    assign if_inst  = if_pkt_q.inst;
    assign if_pc    = if_pkt_q.pc;

    // Memory must never answer while no request is outstanding.
    resp_in_req_a: assert property (@(posedge clk) disable iff (!rstn)
        !(state_q == REQ && imem_resp_valid));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC register and imem models plus an in-order scoreboard.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] pc = '0;
    logic        pc_stall;
    logic [63:0] npc;
    logic        br_taken_exe;
    logic [63:0] br_target_exe;
    logic        trap_valid;
    logic [63:0] trap_vec;
    logic        mret_valid;
    logic [63:0] mepc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int n_deliv  = 0;

    logic [7:0]  mem_cnt  = '0;
    logic [63:0] mem_addr = '0;
    exp_t        sb[$];
    logic        outst   = 1'b0;
    logic        if_seen = 1'b0;

    fetch_ctrl dut (
        .clk             (clk),
        .rstn            (rstn),
        .pc              (pc),
        .pc_stall        (pc_stall),
        .npc             (npc),
        .br_taken_exe    (br_taken_exe),
        .br_target_exe   (br_target_exe),
        .trap_valid      (trap_valid),
        .trap_vec        (trap_vec),
        .mret_valid      (mret_valid),
        .mepc            (mepc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .id_ready        (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // PC register
    always @(posedge clk or negedge rstn) begin
        if (!rstn)          pc <= '0;
        else if (!pc_stall) pc <= npc;
    end

    // Instruction memory: answers mem_lat cycles after acceptance
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_cnt <= '0;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_cnt  <= 8'(mem_lat);
            mem_addr <= imem_req_addr;
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 8'd1;
        end
    end
    assign imem_resp_valid = (mem_cnt == 8'd1);
    assign imem_resp_data  = inst_of(mem_addr);

    // Scoreboard producer: an accepted request is expected unless a redirect hits before its response
    always @(posedge clk) begin
        exp_t dummy;
        logic redir;
        redir = trap_valid | mret_valid | br_taken_exe;
        if (!rstn) begin
            sb.delete();
            outst = 1'b0;
        end else begin
            if (outst && redir) begin
                dummy = sb.pop_back();
                outst = 1'b0;
            end else if (outst && imem_resp_valid) begin
                outst = 1'b0;
            end
            if (imem_req_valid && imem_req_ready && !redir) begin
                sb.push_back('{pc: imem_req_addr, inst: inst_of(imem_req_addr)});
                outst = 1'b1;
            end
        end
    end

    // Scoreboard consumer: each new if_valid assertion is one delivered instruction
    always @(negedge clk) begin
        exp_t e;
        if (if_valid && !if_seen) begin
            n_deliv++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_if_pc", if_pc, e.pc);
                check("sb_if_inst", 64'(if_inst), 64'(e.inst));
            end
        end
        if_seen = if_valid;
    end

    task automatic wait_req(input logic [63:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(imem_req_valid && imem_req_addr == a) && n < 40);
        check("wait_req_valid", 64'(imem_req_valid), 64'd1);
        check("wait_req_addr", imem_req_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        rstn = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b1;
        br_taken_exe = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
        br_target_exe = '0; trap_vec = '0; mepc = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_inst", 64'(if_inst), 64'd0);
        check("rst_if_pc", if_pc, 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd1);
        check("rst_pc_stall", 64'(pc_stall), 64'd1);
        check("rst_npc", npc, 64'd4);

        // Back-to-back fetch, latency 1: handshake every third cycle at 0, 4, 8
        @(negedge clk); rstn = 1'b1; imem_req_ready = 1'b1; #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (i % 3 == 0) begin
                check("seq_req_valid", 64'(imem_req_valid), 64'd1);
                check("seq_req_addr", imem_req_addr, 64'(4 * (i / 3)));
                check("seq_pc_stall", 64'(pc_stall), 64'd0);
            end else begin
                check("seq_req_idle", 64'(imem_req_valid), 64'd0);
                check("seq_pc_stall_idle", 64'(pc_stall), 64'd1);
            end
        end

        // Memory not ready for 5 cycles
        @(negedge clk); rstn = 1'b0; imem_req_ready = 1'b0;
        @(negedge clk); @(negedge clk); rstn = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            check("nrdy_pc_stall", 64'(pc_stall), 64'd1);
            check("nrdy_pc", pc, 64'd0);
            check("nrdy_req_valid", 64'(imem_req_valid), 64'd1);
        end
        @(negedge clk); imem_req_ready = 1'b1; #1;
        check("rdy_pc_stall", 64'(pc_stall), 64'd0);
        check("rdy_npc", npc, 64'd4);
        check("rdy_req_addr", imem_req_addr, 64'd0);

        // Branch while waiting on a slow response for 0x8
        wait_req(64'h8);
        mem_lat = 3;
        @(negedge clk); br_taken_exe = 1'b1; br_target_exe = 64'h100; #1;
        check("wait_req_valid0", 64'(imem_req_valid), 64'd0);
        check("br_pc_stall", 64'(pc_stall), 64'd0);
        check("br_npc", npc, 64'h100);
        @(negedge clk); br_taken_exe = 1'b0; mem_lat = 1; #1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            check("kill_if_valid", 64'(if_valid), 64'd0);
            check("kill_req_valid", 64'(imem_req_valid), 64'd0);
        end
        wait_req(64'h100);

        // All three redirects at once, then mret+branch while killing
        trap_valid = 1'b1; trap_vec = 64'h80;
        mret_valid = 1'b1; mepc = 64'h200;
        br_taken_exe = 1'b1; br_target_exe = 64'h300; #1;
        check("prio_trap_npc", npc, 64'h80);
        check("prio_pc_stall", 64'(pc_stall), 64'd0);
        @(negedge clk); trap_valid = 1'b0; #1;
        check("prio_mret_npc", npc, 64'h200);
        check("prio_kill_req", 64'(imem_req_valid), 64'd0);
        @(negedge clk); mret_valid = 1'b0; br_taken_exe = 1'b0; id_ready = 1'b0; #1;
        check("mret_req_valid", 64'(imem_req_valid), 64'd1);
        check("mret_req_addr", imem_req_addr, 64'h200);

        // Decode back-pressure holds the instruction
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!if_valid && n < 10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            check("hold_if_valid", 64'(if_valid), 64'd1);
            check("hold_if_pc", if_pc, 64'h200);
            check("hold_if_inst", 64'(if_inst), 64'(inst_of(64'h200)));
            check("hold_req_valid", 64'(imem_req_valid), 64'd0);
        end
        @(negedge clk); br_taken_exe = 1'b1; br_target_exe = 64'h40; #1;
        check("hold_br_npc", npc, 64'h40);
        @(negedge clk); br_taken_exe = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b1; #1;
        check("hold_drop_valid", 64'(if_valid), 64'd0);
        check("hold_next_valid", 64'(imem_req_valid), 64'd1);
        check("hold_next_addr", imem_req_addr, 64'h40);

        // Unaccepted request retargeted to the top of the address space, then wrap
        br_taken_exe = 1'b1; br_target_exe = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        check("retgt_npc", npc, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); br_taken_exe = 1'b0; imem_req_ready = 1'b1; mem_lat = 3; #1;
        check("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc_stall", 64'(pc_stall), 64'd0);
        check("wrap_npc", npc, 64'd0);
        @(negedge clk); #1;
        check("wrap_pc", pc, 64'd0);
        check("wrap_wait", 64'(imem_req_valid), 64'd0);

        // Async reset in WAIT
        imem_req_ready = 1'b0; rstn = 1'b0; #1;
        check("arst_if_valid", 64'(if_valid), 64'd0);
        check("arst_req_valid", 64'(imem_req_valid), 64'd1);
        check("arst_pc_stall", 64'(pc_stall), 64'd1);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1; imem_req_ready = 1'b1; mem_lat = 1; n_deliv = 0;
        repeat (9) @(negedge clk);
        #1;
        check("post_rst_deliv", 64'(n_deliv), 64'd3);
        check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
